load_store_unit: RTL and testbench

- Multi-cycle load/store initiator that sits between the datapath and the word-addressed data memory.
- Converts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into memory read and write cycles.
- Sub-word stores are done as read-modify-write, because the memory only writes whole words.
- The memory returns memData combinationally while memRead is high and writes on posedge when memWrite is high.

---
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator for a word-addressed data memory.
// Sub-word stores use read-modify-write. Define LSU_ALIGN_CHECK_EN to make misaligned
// accesses and size=11 raise err.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        isStore,
  input  logic [1:0]  size,
  input  logic        signedLoad,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] loadData,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] memData
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state;
  logic        op_store;
  logic        op_signed;
  logic [1:0]  op_size;
  logic [1:0]  op_off;
  logic [15:0] op_data;

  logic        range_err;
  logic        acc_err;
  logic [1:0]  acc_size;
  logic [1:0]  acc_off;

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] off, input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   r = sgn ? 32'(b) : {24'h0, b};
      2'b01:   r = sgn ? 32'(h) : {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [15:0] data,
                                              input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    if (sz == 2'b00)
      r[8*off +: 8] = data[7:0];
    else
      r[16*off[1] +: 16] = data;
    return r;
  endfunction

  always_comb range_err = |addr[31:ADDR_W+2];

`ifdef LSU_ALIGN_CHECK_EN
  always_comb begin
    acc_size = size;
    acc_off  = addr[1:0];
    acc_err  = range_err || (size == 2'b11) || (size == 2'b01 && addr[0]) ||
               (size == 2'b10 && addr[1:0] != 2'b00);
  end
`else
  // Misaligned accesses are aligned down; size=11 behaves as a word.
  always_comb begin
    acc_size = (size == 2'b11) ? 2'b10 : size;
    case (acc_size)
      2'b00:   acc_off = addr[1:0];
      2'b01:   acc_off = {addr[1], 1'b0};
      default: acc_off = 2'b00;
    endcase
    acc_err = range_err;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      memRead      <= 1'b0;
      memWrite     <= 1'b0;
      loadData     <= '0;
      memAddress   <= '0;
      memWriteData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            busy       <= 1'b1;
            op_store   <= isStore;
            op_signed  <= signedLoad;
            op_size    <= acc_size;
            op_off     <= acc_off;
            op_data    <= storeData[15:0];
            memAddress <= 32'(addr[ADDR_W+1:2]);
            if (acc_err) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (!isStore || acc_size != 2'b10) begin
              state   <= RD;
              memRead <= 1'b1;
            end else begin
              state        <= WR;
              memWrite     <= 1'b1;
              memWriteData <= storeData;
            end
          end
        end
        RD: begin
          memRead <= 1'b0;
          if (op_store) begin
            state        <= WR;
            memWrite     <= 1'b1;
            memWriteData <= merge_store(memData, op_data, op_size, op_off);
          end else begin
            state    <= DONE;
            done     <= 1'b1;
            loadData <= extend_load(memData, op_size, op_off, op_signed);
          end
        end
        WR: begin
          memWrite <= 1'b0;
          state    <= DONE;
          done     <= 1'b1;
        end
        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, word-array memory
// model on the DUT side, directed cases followed by randomized traffic.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        isStore;
  logic [1:0]  size;
  logic        signedLoad;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] loadData;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memData;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .isStore(isStore), .size(size),
    .signedLoad(signedLoad), .addr(addr), .storeData(storeData), .busy(busy),
    .done(done), .err(err), .loadData(loadData), .memAddress(memAddress),
    .memWriteData(memWriteData), .memRead(memRead), .memWrite(memWrite), .memData(memData)
  );

  logic [31:0] mem [0:255];
  logic [7:0]  ref_b [0:1023];

  assign memData = memRead ? mem[memAddress[7:0]] : 32'h0;
  always @(posedge clk) if (memWrite) mem[memAddress[7:0]] <= memWriteData;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          lat;
    int          reads;
    int          writes;
    int          widx;
    logic        chk_mem;
    logic [31:0] word;
    int          acc;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          passed = 0;
  int          total  = 0;
  logic [31:0] held   = 32'h0;
  int          rd_n = 0, wr_n = 0, wr_total = 0;
  logic [31:0] last_ma = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[w*4+3], ref_b[w*4+2], ref_b[w*4+1], ref_b[w*4]};
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (reset) begin
      rd_n = 0;
      wr_n = 0;
    end else begin
      if (memRead || memWrite) begin
        chk("rd_wr_exclusive", 32'(memRead & memWrite), 32'h0);
        last_ma = memAddress;
      end
      if (memRead) rd_n++;
      if (memWrite) begin
        wr_n++;
        wr_total++;
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'h1, 32'h0);
        end else begin
          e = q.pop_front();
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          chk("err", 32'(err), 32'(e.err));
          chk("loadData", loadData, e.data);
          chk("read_cycles", 32'(rd_n), 32'(e.reads));
          chk("write_cycles", 32'(wr_n), 32'(e.writes));
          chk("busy_in_done", 32'(busy), 32'h1);
          if (e.reads + e.writes > 0) chk("mem_addr", last_ma, 32'(e.widx));
          if (e.chk_mem) chk("mem_word", mem[e.widx], e.word);
        end
        rd_n = 0;
        wr_n = 0;
      end
    end
  end

  task automatic set_word(input int idx, input logic [31:0] val);
    mem[idx] <= val;
    for (int i = 0; i < 4; i++) ref_b[idx*4+i] = val[8*i +: 8];
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge in the following IDLE cycle.
  task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d, input logic hold);
    exp_t        x;
    logic        bad;
    int          esz, base, nb;
    logic [31:0] val;
    bit          seen;
    bad = (a[31:10] != 22'h0);
`ifdef LSU_ALIGN_CHECK_EN
    esz  = int'(sz);
    bad  = bad || (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    base = int'(a[9:0]);
`else
    esz  = (sz == 2'b11) ? 2 : int'(sz);
    base = int'(a[9:0]) & ~((1 << esz) - 1);
`endif
    nb        = 1 << esz;
    x.err     = bad;
    x.lat     = bad ? 1 : ((st && esz != 2) ? 3 : 2);
    x.reads   = bad ? 0 : ((st && esz == 2) ? 0 : 1);
    x.writes  = (st && !bad) ? 1 : 0;
    x.widx    = base / 4;
    x.chk_mem = 1'b0;
    x.word    = 32'h0;
    if (!bad) begin
      if (st) begin
        for (int i = 0; i < nb; i++) ref_b[base+i] = d[8*i +: 8];
        x.chk_mem = 1'b1;
        x.word    = ref_word(base / 4);
      end else begin
        val = 32'h0;
        for (int i = 0; i < nb; i++) val = val | (32'(ref_b[base+i]) << (8*i));
        if (sg && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
        held = val;
      end
    end
    x.data = held;
    x.acc  = cyc + 1;
    q.push_back(x);
    req = 1'b1; isStore = st; size = sz; signedLoad = sg; addr = a; storeData = d;
    @(posedge clk);
    #1;
    if (!hold) begin
      req = 1'b0;
      addr = $urandom; storeData = $urandom; size = 2'($urandom); isStore = 1'($urandom);
    end
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) chk("done_timeout", 32'h0, 32'h1);
    req = 1'b0;
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          wsnap;
    logic [31:0] sw;
    reset = 1'b1; req = 1'b0; isStore = 1'b0; size = 2'b00; signedLoad = 1'b0;
    addr = 32'h0; storeData = 32'h0;
    for (int i = 0; i < 256; i++) set_word(i, $urandom);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_loadData", loadData, 32'h0);
    chk("rst_memAddress", memAddress, 32'h0);
    chk("rst_memWriteData", memWriteData, 32'h0);
    chk("rst_memRead", 32'(memRead), 32'h0);
    chk("rst_memWrite", 32'(memWrite), 32'h0);
    reset = 1'b0;
    held  = 32'h0;
    @(negedge clk);

    set_word(3, 32'h8899AABB);
    issue(1'b0, 2'b00, 1'b1, 32'h0E, 32'h0, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h0C, 32'h0, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, 1'b0);
    set_word(5, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h15, 32'h5A, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0);
    issue(1'b0, 2'b11, 1'b1, 32'h08, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 1'b0);
    issue(1'b1, 2'b01, 1'b0, 32'h8000_0010, 32'h1234, 1'b0);

    // req held high across the whole access must produce exactly one transaction.
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no_second_access", 32'(done | busy), 32'h0);
    end

    // Reset during the read phase of a read-modify-write.
    set_word(7, 32'hCAFEF00D);
    wsnap = wr_total;
    sw    = ref_word(7);
    @(negedge clk);
    req = 1'b1; isStore = 1'b1; size = 2'b00; signedLoad = 1'b0; addr = 32'h1C; storeData = 32'h77;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    chk("rmw_in_rd", 32'(memRead), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    held  = 32'h0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_memWrite", 32'(memWrite), 32'h0);
    chk("abort_loadData", loadData, 32'h0);
    repeat (4) @(negedge clk);
    chk("abort_no_write", 32'(wr_total), 32'(wsnap));
    chk("abort_word", mem[7], sw);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'($urandom_range(0, 7) == 0));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
